// File: rtl/luna_led_pkg.sv
// Shared encodings for the LED pattern player: playback modes and FSM states.
package luna_led_pkg;

  typedef enum logic [1:0] {
    MODE_ONE_SHOT  = 2'd0,
    MODE_LOOP      = 2'd1,
    MODE_PING_PONG = 2'd2,
    MODE_RESERVED  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } state_e;

  // The reserved encoding plays exactly like one-shot.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_LOOP;
      2'd2:    return MODE_PING_PONG;
      default: return MODE_ONE_SHOT;
    endcase
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step-period down-counter: load a value, count down to zero and hold there.
module led_step_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic [DIV_W-1:0] count,
  output logic             expired
);

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/led_pattern_player.sv
// Plays a sequence of BRAM words onto the LEDs in one-shot, loop or ping-pong order.
module led_pattern_player
  import luna_led_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int ADDR_W   = 16,
  parameter int DIV_W    = 24,
  parameter int BRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DIV_W-1:0]  div,
  input  logic [15:0]       bram_doutb,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [N_LEDS-1:0] leds,
  output logic              busy,
  output logic              done
);

  localparam logic [DIV_W-1:0] MIN_PM1  = DIV_W'(BRAM_LAT + 1);
  localparam logic [DIV_W-1:0] FETCH_AT = DIV_W'(BRAM_LAT + 2);
  localparam logic [1:0]       LAT_LAST = 2'(BRAM_LAT - 1);

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [ADDR_W-1:0] base_q, len_q, idx_q, idx_next, last_idx;
  logic [DIV_W-1:0]  div_q, period_m1, step_count;
  logic              dir_down_q, dir_next, last_q, is_last, step_expired;
  logic [1:0]        wait_q;
  logic [1:0]        sync_q;
  logic              run_en;
  logic              capture, fetch, latch, finish, zero_done;

  // Release is re-timed so the first edge after rst_n rises never accepts start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign run_en = sync_q[1];

  assign last_idx  = len_q - 1'b1;
  assign is_last   = (mode_q == MODE_ONE_SHOT) && (idx_q == last_idx);
  assign period_m1 = (div_q > MIN_PM1) ? div_q : MIN_PM1;

  led_step_timer #(.DIV_W(DIV_W)) u_step_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (latch),
    .value   (period_m1),
    .count   (step_count),
    .expired (step_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    fetch     = 1'b0;
    latch     = 1'b0;
    finish    = 1'b0;
    zero_done = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && run_en) begin
            if (length == '0) begin
              zero_done = 1'b1;
            end else begin
              capture = 1'b1;
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          fetch   = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (wait_q == LAT_LAST) state_d = LATCH;
        end
        LATCH: begin
          latch = 1'b1;
          // At the minimum period the next fetch must start right away.
          if (!is_last && period_m1 == MIN_PM1) state_d = FETCH;
          else                                  state_d = HOLD;
        end
        HOLD: begin
          if (last_q) begin
            if (step_expired) begin
              finish  = 1'b1;
              state_d = IDLE;
            end
          end else if (step_count <= FETCH_AT) begin
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    idx_next = idx_q + 1'b1;
    dir_next = dir_down_q;
    case (mode_q)
      MODE_LOOP: begin
        if (idx_q == last_idx) idx_next = '0;
      end
      MODE_PING_PONG: begin
        if (last_idx == '0) begin
          idx_next = '0;
        end else if (!dir_down_q) begin
          if (idx_q == last_idx) begin
            idx_next = idx_q - 1'b1;
            dir_next = 1'b1;
          end
        end else if (idx_q == '0) begin
          dir_next = 1'b0;
        end else begin
          idx_next = idx_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_ONE_SHOT;
      base_q     <= '0;
      len_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      dir_down_q <= 1'b0;
      last_q     <= 1'b0;
      wait_q     <= '0;
      bram_addrb <= '0;
      leds       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= zero_done | finish;
      if (capture) begin
        mode_q     <= decode_mode(mode);
        base_q     <= base_addr;
        len_q      <= length;
        div_q      <= div;
        idx_q      <= '0;
        dir_down_q <= 1'b0;
        last_q     <= 1'b0;
        busy       <= 1'b1;
      end
      if (stop || finish) busy <= 1'b0;
      if (fetch) begin
        bram_addrb <= base_q + idx_q;
        wait_q     <= '0;
      end else if (state_q == WAIT) begin
        wait_q <= wait_q + 1'b1;
      end
      if (latch) begin
        leds       <= bram_doutb[N_LEDS-1:0];
        idx_q      <= idx_next;
        dir_down_q <= dir_next;
        last_q     <= is_last;
      end
    end
  end

  generate
    if (N_LEDS < 16) begin : g_unused_bits
      logic unused_doutb;
      assign unused_doutb = ^bram_doutb[15:N_LEDS];
    end
  endgenerate

endmodule

// File: tb/tb_led_pattern_player.sv
// Cycle-accurate bench for led_pattern_player against a schedule-based reference model.
module tb_led_pattern_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] base_addr = '0, length = '0;
  logic [23:0] div = '0;
  logic [15:0] dout_a, dout_b, addr_a, addr_b;
  logic [7:0]  leds_a, leds_b;
  logic        busy_a, busy_b, done_a, done_b;

  logic [15:0] mem [0:65535];
  logic [15:0] pipe_a;
  logic [15:0] pipe_b [0:1];

  int checks = 0;
  int errors = 0;
  logic [7:0]  model_leds [0:1];
  logic [15:0] model_addr [0:1];

  always #5 clk = ~clk;

  // BRAM models: one-cycle and two-cycle read latency.
  always @(posedge clk) begin
    pipe_a    <= mem[addr_a];
    pipe_b[0] <= mem[addr_b];
    pipe_b[1] <= pipe_b[0];
  end
  assign dout_a = pipe_a;
  assign dout_b = pipe_b[1];

  led_pattern_player #(.N_LEDS(8), .ADDR_W(16), .DIV_W(24), .BRAM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .mode(mode),
    .base_addr(base_addr), .length(length), .div(div), .bram_doutb(dout_a),
    .bram_addrb(addr_a), .leds(leds_a), .busy(busy_a), .done(done_a)
  );

  led_pattern_player #(.N_LEDS(8), .ADDR_W(16), .DIV_W(24), .BRAM_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .mode(mode),
    .base_addr(base_addr), .length(length), .div(div), .bram_doutb(dout_b),
    .bram_addrb(addr_b), .leds(leds_b), .busy(busy_b), .done(done_b)
  );

  // Index of the j-th word shown, straight from the playback-order rules.
  function automatic int seq_idx(input int md, input int len, input int j);
    int p;
    if (md == 1) return j % len;
    if (md == 2) begin
      if (len == 1) return 0;
      p = j % (2 * (len - 1));
      return (p < len) ? p : 2 * (len - 1) - p;
    end
    return j;
  endfunction

  // Starts a run on one instance and checks every cycle against the schedule:
  // word j appears at edge (LAT+2)+j*P, its fetch at edge 1+j*P, done at (LAT+2)+len*P.
  task automatic play(input int inst, input logic [1:0] md, input logic [15:0] b,
                      input int len, input int dv, input int n_cycles, input int stop_at);
    int lat, first, per, md_e, fin, ke, nu, nf;
    bit stopped;
    logic [15:0] a, exp_addr, obs_addr;
    logic [7:0]  exp_leds, obs_leds;
    logic        exp_busy, exp_done, obs_busy, obs_done;
    lat   = (inst == 0) ? 1 : 2;
    first = lat + 2;
    per   = (dv + 1 > lat + 2) ? dv + 1 : lat + 2;
    md_e  = (md == 2'd3) ? 0 : int'(md);
    fin   = first + len * per;
    exp_leds = model_leds[inst];
    exp_addr = model_addr[inst];
    mode = md; base_addr = b; length = 16'(len); div = 24'(dv);
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    for (int k = 0; k <= n_cycles; k++) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; stop = 1'b0;
      mode = 2'($urandom); base_addr = 16'($urandom);
      length = 16'($urandom); div = 24'($urandom_range(0, 50));
      stopped = (stop_at >= 0) && (k >= stop_at);
      ke = stopped ? stop_at - 1 : k;
      nu = (ke < first) ? 0 : (ke - first) / per + 1;
      nf = (ke < 1) ? 0 : (ke - 1) / per + 1;
      if (md_e == 0 && nu > len) nu = len;
      if (md_e == 0 && nf > len) nf = len;
      exp_leds = model_leds[inst];
      if (nu > 0) begin
        a = b + 16'(seq_idx(md_e, len, nu - 1));
        exp_leds = mem[a][7:0];
      end
      exp_addr = model_addr[inst];
      if (nf > 0) exp_addr = b + 16'(seq_idx(md_e, len, nf - 1));
      exp_busy = !stopped && (md_e != 0 || k < fin);
      exp_done = !stopped && md_e == 0 && k == fin;
      obs_leds = (inst == 0) ? leds_a : leds_b;
      obs_addr = (inst == 0) ? addr_a : addr_b;
      obs_busy = (inst == 0) ? busy_a : busy_b;
      obs_done = (inst == 0) ? done_a : done_b;
      checks += 4;
      if (obs_leds !== exp_leds) begin
        errors++;
        $display("FAIL leds inst=%0d k=%0d got %h want %h", inst, k, obs_leds, exp_leds);
      end
      if (obs_addr !== exp_addr) begin
        errors++;
        $display("FAIL bram_addrb inst=%0d k=%0d got %h want %h", inst, k, obs_addr, exp_addr);
      end
      if (obs_busy !== exp_busy) begin
        errors++;
        $display("FAIL busy inst=%0d k=%0d got %b want %b", inst, k, obs_busy, exp_busy);
      end
      if (obs_done !== exp_done) begin
        errors++;
        $display("FAIL done inst=%0d k=%0d got %b want %b", inst, k, obs_done, exp_done);
      end
      if (k + 1 == stop_at) stop = 1'b1;
    end
    model_leds[inst] = exp_leds;
    model_addr[inst] = exp_addr;
  endtask

  task automatic test_reset;
    #12;
    checks += 5;
    if ({leds_a, leds_b} !== 16'h0) begin
      errors++; $display("FAIL reset_leds got %h want 0000", {leds_a, leds_b});
    end
    if ({addr_a, addr_b} !== 32'h0) begin
      errors++; $display("FAIL reset_addr got %h want 0", {addr_a, addr_b});
    end
    if ({busy_a, busy_b, done_a, done_b} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {busy_a, busy_b, done_a, done_b});
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    length = 16'd2; base_addr = 16'h0040; div = 24'd3; mode = 2'd1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL release_edge_start got busy=%b want 0", busy_a);
    end
    repeat (3) @(posedge clk);
    #1;
    if (busy_a !== 1'b0 || leds_a !== 8'h00) begin
      errors++; $display("FAIL after_release got busy=%b leds=%h want 0/00", busy_a, leds_a);
    end
    model_leds[0] = '0; model_leds[1] = '0;
    model_addr[0] = '0; model_addr[1] = '0;
  endtask

  task automatic test_one_shot;
    mem[16'h0010] = 16'h0001; mem[16'h0011] = 16'h0002;
    mem[16'h0012] = 16'h0004; mem[16'h0013] = 16'h0008;
    play(0, 2'd0, 16'h0010, 4, 9, 50, -1);
    checks++;
    if (leds_a !== 8'h08) begin
      errors++; $display("FAIL one_shot_final got %h want 08", leds_a);
    end
  endtask

  task automatic test_loop_wrap;
    mem[16'hFFFE] = 16'($urandom); mem[16'hFFFF] = 16'($urandom); mem[16'h0000] = 16'($urandom);
    play(0, 2'd1, 16'hFFFE, 3, int'($urandom_range(5, 12)), 60, 55);
  endtask

  task automatic test_ping_pong;
    mem[16'h0100] = 16'h00A1; mem[16'h0101] = 16'h00B2; mem[16'h0102] = 16'h00C3;
    play(0, 2'd2, 16'h0100, 3, 6, 60, 58);
    mem[16'h0200] = 16'h005A;
    play(0, 2'd2, 16'h0200, 1, 4, 30, 28);
  endtask

  task automatic test_min_period;
    for (int i = 0; i < 5; i++) mem[16'h0300 + 16'(i)] = 16'($urandom);
    play(1, 2'd0, 16'h0300, 5, 0, 28, -1);
  endtask

  task automatic test_abort;
    play(0, 2'd0, 16'h0010, 4, 20, 30, 8);
    start_a = 1'b1; stop = 1'b1; length = 16'd3; mode = 2'd1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start_a = 1'b0; stop = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || leds_a !== model_leds[0] || addr_a !== model_addr[0]) begin
        errors++;
        $display("FAIL start_stop_idle k=%0d got busy=%b done=%b leds=%h addr=%h want 0/0/%h/%h",
                 k, busy_a, done_a, leds_a, addr_a, model_leds[0], model_addr[0]);
      end
    end
  endtask

  task automatic test_zero_length;
    length = 16'd0; base_addr = 16'h0500; div = 24'd2; mode = 2'd0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL zero_len_pulse got done=%b busy=%b want 1/0", done_a, busy_a);
    end
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || leds_a !== model_leds[0] || addr_a !== model_addr[0]) begin
      errors++;
      $display("FAIL zero_len_after got done=%b leds=%h addr=%h want 0/%h/%h",
               done_a, leds_a, addr_a, model_leds[0], model_addr[0]);
    end
  endtask

  task automatic test_random;
    int inst, md, len, dv, lat, per, n, sa;
    logic [15:0] b;
    for (int r = 0; r < 6; r++) begin
      inst = int'($urandom_range(0, 1));
      md   = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 5));
      dv   = int'($urandom_range(0, 8));
      b    = 16'($urandom);
      for (int i = 0; i < len; i++) mem[b + 16'(i)] = 16'($urandom);
      lat = (inst == 0) ? 1 : 2;
      per = (dv + 1 > lat + 2) ? dv + 1 : lat + 2;
      if (md == 0 || md == 3) begin
        n  = lat + 2 + len * per + 3;
        sa = -1;
      end else begin
        n  = lat + 2 + 2 * len * per + 4;
        sa = n - 3;
      end
      play(inst, 2'(md), b, len, dv, n, sa);
    end
  endtask

  task automatic test_reset_mid_play;
    play(0, 2'd1, 16'h0010, 4, 3, 20, -1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({leds_a, leds_b, addr_a, addr_b, busy_a, done_a} !== 50'h0) begin
      errors++;
      $display("FAIL reset_mid_play got leds=%h/%h addr=%h/%h busy=%b done=%b want all 0",
               leds_a, leds_b, addr_a, addr_b, busy_a, done_a);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || leds_a !== 8'h00) begin
      errors++; $display("FAIL post_reset_idle got busy=%b leds=%h want 0/00", busy_a, leds_a);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_loop_wrap();
    test_ping_pong();
    test_min_period();
    test_abort();
    test_zero_length();
    test_random();
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
